// File: rtl/rvseed_pkg.sv
// rtl/rvseed_pkg.sv - shared rvseed types: owner encoding, arbiter lock default, memory command
package rvseed_pkg;

  localparam int CPU_WIDTH         = 32;
  localparam int DMEM_AW           = 32;
  localparam int DMEM_ARB_MAX_LOCK = 8;

  typedef enum logic {
    OWN_M0 = 1'b0,
    OWN_M1 = 1'b1
  } owner_e;

  typedef struct packed {
    logic                   we;
    logic [DMEM_AW-1:0]     addr;
    logic [CPU_WIDTH-1:0]   wdata;
    logic [CPU_WIDTH/8-1:0] wstrb;
  } dmem_cmd_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - requester and memory signals of the data-memory arbiter
interface dmem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);

  logic            m0_req;
  logic            m0_we;
  logic [AW-1:0]   m0_addr;
  logic [DW-1:0]   m0_wdata;
  logic [DW/8-1:0] m0_wstrb;
  logic            m0_gnt;
  logic            m0_rvalid;
  logic [DW-1:0]   m0_rdata;

  logic            m1_req;
  logic            m1_we;
  logic [AW-1:0]   m1_addr;
  logic [DW-1:0]   m1_wdata;
  logic [DW/8-1:0] m1_wstrb;
  logic            m1_lock;
  logic            m1_gnt;
  logic            m1_rvalid;
  logic [DW-1:0]   m1_rdata;

  logic            mem_en;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW/8-1:0] mem_wstrb;
  logic [DW-1:0]   mem_rdata;

  // Arbiter side
  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata, m0_wstrb,
    output m0_gnt, m0_rvalid, m0_rdata,
    input  m1_req, m1_we, m1_addr, m1_wdata, m1_wstrb, m1_lock,
    output m1_gnt, m1_rvalid, m1_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_rdata
  );

  // Requesters plus memory side
  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata, m0_wstrb,
    input  m0_gnt, m0_rvalid, m0_rdata,
    output m1_req, m1_we, m1_addr, m1_wdata, m1_wstrb, m1_lock,
    input  m1_gnt, m1_rvalid, m1_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_rdata
  );

endinterface

// File: rtl/dmem_arb_pick.sv
// rtl/dmem_arb_pick.sv - combinational winner select; DMEM_ARB_RR_EN selects round-robin contention
module dmem_arb_pick
  import rvseed_pkg::*;
(
  input  logic   m0_req_i,
  input  logic   m1_req_i,
  input  logic   m1_lock_i,
  input  owner_e last_gnt_i,
  input  logic   lock_sat_i,
  output logic   m0_gnt_o,
  output logic   m1_gnt_o
);

  // M1 keeps a locked burst only while it still owns the port and the guard is not exhausted
  logic lock_hold;
  assign lock_hold = m1_lock_i && (last_gnt_i == OWN_M1) && m1_req_i && !lock_sat_i;

  // Winner selection: lone requester, then lock, then contention policy
  always_comb begin
    m0_gnt_o = 1'b0;
    m1_gnt_o = 1'b0;
    if (m0_req_i && !m1_req_i) begin
      m0_gnt_o = 1'b1;
    end else if (m1_req_i && !m0_req_i) begin
      m1_gnt_o = 1'b1;
    end else if (m0_req_i && m1_req_i) begin
      if (lock_hold) begin
        m1_gnt_o = 1'b1;
      end else begin
`ifdef DMEM_ARB_RR_EN
        if (last_gnt_i == OWN_M0) begin
          m1_gnt_o = 1'b1;
        end else begin
          m0_gnt_o = 1'b1;
        end
`else
        m0_gnt_o = 1'b1;
`endif
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-requester data-memory arbiter with grant/access/response pipeline
module dmem_arbiter
  import rvseed_pkg::*;
#(
  parameter int AW       = DMEM_AW,
  parameter int DW       = CPU_WIDTH,
  parameter int MAX_LOCK = DMEM_ARB_MAX_LOCK
) (
  input logic           clk,
  input logic           rst,
  dmem_arbiter_if.slave bus
);

  localparam int LCW = $clog2(MAX_LOCK + 1);

  typedef struct packed {
    logic            we;
    logic [AW-1:0]   addr;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wstrb;
  } cmd_t;

  logic           m0_win;
  logic           m1_win;
  logic           lock_sat;

  owner_e         last_gnt_q, last_gnt_d;
  logic [LCW-1:0] lock_cnt_q, lock_cnt_d;

  logic           a_vld_q, a_vld_d;
  owner_e         a_own_q, a_own_d;
  cmd_t           a_cmd_q, a_cmd_d;

  logic           r_vld_q;
  owner_e         r_own_q;
  logic           r_we_q;

  assign lock_sat = (lock_cnt_q >= LCW'(MAX_LOCK));

  dmem_arb_pick u_pick (
    .m0_req_i   (bus.m0_req),
    .m1_req_i   (bus.m1_req),
    .m1_lock_i  (bus.m1_lock),
    .last_gnt_i (last_gnt_q),
    .lock_sat_i (lock_sat),
    .m0_gnt_o   (m0_win),
    .m1_gnt_o   (m1_win)
  );

  // No command may be accepted while reset is held
  assign bus.m0_gnt = m0_win & ~rst;
  assign bus.m1_gnt = m1_win & ~rst;

  // Next-state for stage A, grant history and lock counter
  always_comb begin
    a_vld_d    = bus.m0_gnt | bus.m1_gnt;
    a_own_d    = bus.m1_gnt ? OWN_M1 : OWN_M0;
    a_cmd_d    = '0;
    last_gnt_d = last_gnt_q;
    lock_cnt_d = lock_cnt_q;
    if (bus.m0_gnt) begin
      a_cmd_d    = '{we: bus.m0_we, addr: bus.m0_addr, wdata: bus.m0_wdata, wstrb: bus.m0_wstrb};
      last_gnt_d = OWN_M0;
    end else if (bus.m1_gnt) begin
      a_cmd_d    = '{we: bus.m1_we, addr: bus.m1_addr, wdata: bus.m1_wdata, wstrb: bus.m1_wstrb};
      last_gnt_d = OWN_M1;
    end
    if (!bus.m0_req || bus.m0_gnt) begin
      lock_cnt_d = '0;
    end else if (bus.m1_gnt && !lock_sat) begin
      lock_cnt_d = lock_cnt_q + LCW'(1);
    end
  end

  // Arbitration state; M1 as last owner lets M0 win the first contention
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_gnt_q <= OWN_M1;
      lock_cnt_q <= '0;
    end else begin
      last_gnt_q <= last_gnt_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  // Access pipeline: stage A drives memory, stage R routes the completion
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_vld_q <= 1'b0;
      a_own_q <= OWN_M0;
      a_cmd_q <= '0;
      r_vld_q <= 1'b0;
      r_own_q <= OWN_M0;
      r_we_q  <= 1'b0;
    end else begin
      a_vld_q <= a_vld_d;
      a_own_q <= a_own_d;
      a_cmd_q <= a_cmd_d;
      r_vld_q <= a_vld_q;
      r_own_q <= a_own_q;
      r_we_q  <= a_cmd_q.we;
    end
  end

  // Stage A command is zero whenever it is not valid, so memory fields idle at 0
  assign bus.mem_en    = a_vld_q;
  assign bus.mem_we    = a_cmd_q.we;
  assign bus.mem_addr  = a_cmd_q.addr;
  assign bus.mem_wdata = a_cmd_q.wdata;
  assign bus.mem_wstrb = a_cmd_q.wstrb;

  assign bus.m0_rvalid = r_vld_q && (r_own_q == OWN_M0);
  assign bus.m1_rvalid = r_vld_q && (r_own_q == OWN_M1);
  assign bus.m0_rdata  = (bus.m0_rvalid && !r_we_q) ? bus.mem_rdata : '0;
  assign bus.m1_rdata  = (bus.m1_rvalid && !r_we_q) ? bus.mem_rdata : '0;

endmodule
